// File: rtl/spike_event_collector_pkg.sv
// Shared definitions for the spike event collector:
// default widths, FSM encoding and event record sizing.
package spike_event_collector_pkg;

   localparam int POST_WIDTH_DEF = 32;
   localparam int DEPTH_DEF      = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HOLD,
      ST_GAP,
      ST_DONE
   } state_t;

   // An event record is {local neuron id, payload}.
   function automatic int rec_width(input int pw);
      return 2 * pw;
   endfunction

endpackage

// File: rtl/spike_event_collector_fifo.sv
// Synchronous event FIFO, one write and one read port.
// Read data is the current head, valid whenever empty is low.
module spike_event_collector_fifo
   import spike_event_collector_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);

endmodule

// File: rtl/spike_event_collector.sv
// Accepts post-synaptic spike events, filters them to the downstream
// layer's address range, and replays them as pre-synaptic inputs.
module spike_event_collector
   import spike_event_collector_pkg::*;
#(
   parameter int POST_WIDTH  = POST_WIDTH_DEF,
   parameter int DEPTH       = DEPTH_DEF,
   parameter int HOLD_CYCLES = 3,
   parameter int GAP_CYCLES  = 0,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  post_req,
   input  logic [POST_WIDTH-1:0] post_waddr,
   input  logic [POST_WIDTH-1:0] post_wdata,
   output logic                  post_grant,
   input  logic [POST_WIDTH-1:0] addr_offset,
   input  logic [15:0]           output_neuron_num,
   input  logic                  layer_done,
   output logic                  pre_grant,
   output logic [POST_WIDTH-1:0] w_data,
   output logic [POST_WIDTH-1:0] w_value,
   output logic                  drain_done,
   output logic [CNT_WIDTH-1:0]  evt_count,
   output logic [CNT_WIDTH-1:0]  drop_count
);

   localparam int REC_W = rec_width(POST_WIDTH);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] GAP_LAST =
      (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

   logic [POST_WIDTH-1:0] local_addr;
   logic                  in_range;
   logic                  accept;
   logic                  push;
   logic                  drop;
   logic                  pop;
   logic                  full;
   logic                  empty;
   logic [REC_W-1:0]      head;

   state_t      state;
   state_t      state_nx;
   logic [15:0] cyc_cnt;
   logic [15:0] cyc_cnt_nx;
   logic        done_latch;

   assign local_addr = post_waddr - addr_offset;
   assign in_range   = (post_waddr >= addr_offset) &&
                       (local_addr < POST_WIDTH'(output_neuron_num));
   assign post_grant = !full;
   assign accept     = post_req && post_grant;
   assign push       = accept && in_range;
   assign drop       = accept && !in_range;

   spike_event_collector_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data ({local_addr, post_wdata}),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   // Pending events always win over the drain, so a timestep only
   // completes once every queued event has been replayed.
   always_comb begin
      state_nx   = state;
      cyc_cnt_nx = cyc_cnt;
      pop        = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (!empty) begin
               state_nx = ST_LOAD;
            end else if (done_latch) begin
               state_nx = ST_DONE;
            end
         end
         ST_LOAD: begin
            pop        = 1'b1;
            cyc_cnt_nx = '0;
            state_nx   = ST_HOLD;
         end
         ST_HOLD: begin
            if (cyc_cnt == HOLD_LAST) begin
               cyc_cnt_nx = '0;
               state_nx   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end else begin
               cyc_cnt_nx = cyc_cnt + 16'd1;
            end
         end
         ST_GAP: begin
            if (cyc_cnt == GAP_LAST) begin
               cyc_cnt_nx = '0;
               state_nx   = ST_IDLE;
            end else begin
               cyc_cnt_nx = cyc_cnt + 16'd1;
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cyc_cnt    <= '0;
         pre_grant  <= 1'b0;
         w_data     <= '0;
         w_value    <= '0;
         done_latch <= 1'b0;
         evt_count  <= '0;
         drop_count <= '0;
      end else begin
         state      <= state_nx;
         cyc_cnt    <= cyc_cnt_nx;
         pre_grant  <= (state == ST_HOLD);
         done_latch <= layer_done | (done_latch & (state != ST_DONE));
         if (pop) begin
            {w_data, w_value} <= head;
         end
         if (push && (evt_count != '1)) begin
            evt_count <= evt_count + 1'b1;
         end
         if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
         end
      end
   end

   assign drain_done = (state == ST_DONE);

endmodule

// File: tb/tb_spike_event_collector.sv
// Scoreboard bench: stimulus queues expected replays, a negedge
// monitor compares them as pre_grant events appear.
module tb_spike_event_collector;

   localparam int PW   = 32;
   localparam int HOLD = 3;

   typedef struct {
      logic [PW-1:0] a;
      logic [PW-1:0] v;
   } ev_t;

   logic          clk;
   logic          rst;
   logic          post_req;
   logic [PW-1:0] post_waddr;
   logic [PW-1:0] post_wdata;
   logic          post_grant;
   logic [PW-1:0] addr_offset;
   logic [15:0]   output_neuron_num;
   logic          layer_done;
   logic          pre_grant;
   logic [PW-1:0] w_data;
   logic [PW-1:0] w_value;
   logic          drain_done;
   logic [15:0]   evt_count;
   logic [15:0]   drop_count;

   spike_event_collector #(
      .POST_WIDTH  (PW),
      .DEPTH       (16),
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (0),
      .CNT_WIDTH   (16)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .post_req          (post_req),
      .post_waddr        (post_waddr),
      .post_wdata        (post_wdata),
      .post_grant        (post_grant),
      .addr_offset       (addr_offset),
      .output_neuron_num (output_neuron_num),
      .layer_done        (layer_done),
      .pre_grant         (pre_grant),
      .w_data            (w_data),
      .w_value           (w_value),
      .drain_done        (drain_done),
      .evt_count         (evt_count),
      .drop_count        (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int  tests = 0;
   int  failed = 0;
   int  cyc = 0;
   ev_t exp_q[$];
   int  exp_evt = 0;
   int  exp_drop = 0;
   bit  flush = 1'b1;
   bit  lat_chk = 1'b0;
   int  acc_edge = 0;
   int  drain_mode = 0;
   int  ld_cyc = 0;
   bit  bp_track = 1'b0;
   bit  bp_seen = 1'b0;
   bit  bp_done = 1'b0;
   int  bp_low = 0;
   int  hi_cnt = 0;
   bit  pg_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      failed++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      ev_t e;
      bit  fell;
      if (rst || flush) begin
         hi_cnt  = 0;
         pg_prev = 1'b0;
      end else begin
         fell = !pre_grant && pg_prev;
         if (pre_grant && !pg_prev) begin
            if (exp_q.size() == 0) begin
               tests++;
               failed++;
               $display("FAIL unexpected_event: w_data=%0h w_value=%0h",
                        w_data, w_value);
            end else begin
               e = exp_q.pop_front();
               chk("w_data", w_data, e.a);
               chk("w_value", w_value, e.v);
               if (lat_chk) chk("latency_edge", cyc, acc_edge + 3);
            end
         end
         if (pre_grant) begin
            hi_cnt++;
         end else if (pg_prev) begin
            chk("hold_len", hi_cnt, HOLD);
            hi_cnt = 0;
         end
         if (drain_done) begin
            if (drain_mode == 0) begin
               tests++;
               failed++;
               $display("FAIL stray_drain: drain_done=1 expected 0");
            end else if (drain_mode == 1) begin
               chk("drain_after_hold", {fell, exp_q.size() == 0}, 2'b11);
            end else begin
               chk("drain_empty_cyc", cyc, ld_cyc + 2);
            end
            drain_mode = 0;
         end
         pg_prev = pre_grant;
      end
   end

   task automatic do_reset();
      flush      = 1'b1;
      rst        = 1'b1;
      post_req   = 1'b0;
      layer_done = 1'b0;
      exp_q.delete();
      drain_mode = 0;
      exp_evt    = 0;
      exp_drop   = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_pre_grant", pre_grant, 0);
      chk("rst_post_grant", post_grant, 1);
      chk("rst_w_data", w_data, 0);
      chk("rst_w_value", w_value, 0);
      chk("rst_drain", drain_done, 0);
      chk("rst_evt_count", evt_count, 0);
      chk("rst_drop_count", drop_count, 0);
      flush = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Leaves post_req high; ok/loc are the hand-computed outcome.
   task automatic send(input logic [PW-1:0] a, input logic [PW-1:0] v,
                       input bit ok, input logic [PW-1:0] loc);
      int w;
      ev_t e;
      post_req   = 1'b1;
      post_waddr = a;
      post_wdata = v;
      w = 0;
      @(negedge clk);
      while (!post_grant && w < 200) begin
         if (bp_track && !bp_seen) begin
            bp_seen = 1'b1;
            chk("bp_depth", exp_evt, 20);
         end
         if (bp_track && !bp_done) bp_low++;
         w++;
         @(negedge clk);
      end
      if (!post_grant) begin
         timeout("grant_wait");
         post_req = 1'b0;
         return;
      end
      if (bp_seen && !bp_done) begin
         bp_done = 1'b1;
         chk("bp_full_cycles", bp_low, 3);
      end
      acc_edge = cyc + 1;
      if (ok) begin
         e.a = loc;
         e.v = v;
         exp_q.push_back(e);
         exp_evt++;
      end else begin
         exp_drop++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int lim);
      int w;
      w = 0;
      while ((exp_q.size() != 0 || pre_grant || drain_mode != 0) &&
             w < lim) begin
         @(negedge clk);
         w++;
      end
      if (w >= lim) timeout("drain_wait");
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_done(input int mode);
      layer_done = 1'b1;
      ld_cyc     = cyc;
      drain_mode = mode;
      @(posedge clk);
      #1 layer_done = 1'b0;
   endtask

   initial begin
      rst               = 1'b1;
      post_req          = 1'b0;
      post_waddr        = '0;
      post_wdata        = '0;
      addr_offset       = '0;
      output_neuron_num = 16'd10;
      layer_done        = 1'b0;
      #2;
      do_reset();

      // single event with latency check
      lat_chk = 1'b1;
      send(32'd3, 32'd2, 1'b1, 32'd3);
      post_req = 1'b0;
      wait_drain(100);
      lat_chk = 1'b0;
      chk("t1_evt_count", evt_count, 1);

      // range drops
      do_reset();
      addr_offset       = 32'd10;
      output_neuron_num = 16'd10;
      send(32'd5, 32'h55, 1'b0, 32'd0);
      send(32'd20, 32'h66, 1'b0, 32'd0);
      send(32'd12, 32'hFFFF_FFF9, 1'b1, 32'd2);
      post_req = 1'b0;
      wait_drain(100);
      chk("t2_drop_count", drop_count, 2);
      chk("t2_evt_count", evt_count, 1);

      // back-pressure and push/pop around full
      do_reset();
      addr_offset       = 32'd100;
      output_neuron_num = 16'd50;
      bp_track = 1'b1;
      for (int i = 0; i < 24; i++) begin
         send(32'd100 + i, 32'h1000 + i, 1'b1, i);
      end
      post_req = 1'b0;
      bp_track = 1'b0;
      chk("t3_bp_seen", bp_seen, 1);
      wait_drain(400);
      chk("t3_evt_count", evt_count, 24);
      chk("t3_drop_count", drop_count, 0);

      // drain after queued events, then with empty FIFO
      do_reset();
      addr_offset       = 32'd0;
      output_neuron_num = 16'd10;
      send(32'd1, 32'h11, 1'b1, 32'd1);
      send(32'd9, 32'h22, 1'b1, 32'd9);
      send(32'd4, 32'h33, 1'b1, 32'd4);
      send(32'd10, 32'h44, 1'b0, 32'd0);
      send(32'd0, 32'h55, 1'b1, 32'd0);
      post_req = 1'b0;
      pulse_done(1);
      wait_drain(200);
      pulse_done(2);
      wait_drain(50);
      repeat (10) @(posedge clk);
      #1;
      chk("t5_evt_count", evt_count, 4);
      chk("t5_drop_count", drop_count, 1);

      // reset in the middle of HOLD
      do_reset();
      send(32'd2, 32'hA, 1'b1, 32'd2);
      send(32'd5, 32'hB, 1'b1, 32'd5);
      send(32'd7, 32'hC, 1'b1, 32'd7);
      post_req = 1'b0;
      begin
         int w;
         w = 0;
         while (!pre_grant && w < 50) begin
            @(negedge clk);
            w++;
         end
         if (!pre_grant) timeout("t6_hold_wait");
      end
      do_reset();
      repeat (30) @(posedge clk);
      #1;
      chk("t6_post_grant", post_grant, 1);
      chk("t6_pre_grant", pre_grant, 0);
      chk("t6_evt_count", evt_count, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
